sprite_fetch: RTL and testbench

//   Per-object pixel source feeding color_mapper: one instance each for mario, luigi, gomba, coin.
//   Hit-tests DrawX/DrawY against the object's frame-latched position and drives the sprite ROM address.

---
 rtl/sprite_fetch.sv | 172 +++++++++++++++++
 tb/tb_sprite_fetch.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/sprite_fetch.sv
// sprite_fetch: per-object pixel source for color_mapper.
// It hit-tests DrawX/DrawY against the position latched at frame_start and drives
// the sprite ROM address. The hit flag is aligned to the ROM read latency, the key
// colour is treated as transparent, and the walk-animation frame index is sequenced.
// Latency from DrawX/DrawY to o_obj_on/o_obj_pix is 1+ROM_LAT clocks. rom_data is
// taken to be valid ROM_LAT cycles after o_rom_addr, counting the address register.
// Optional feature: define SPRITE_MIRROR_EN to enable horizontal flip on face_left.
module sprite_fetch #(
    parameter int          SPR_W    = 32,
    parameter int          SPR_H    = 32,
    parameter int          N_FRAMES = 4,
    parameter int          ADDR_W   = 12,
    parameter int          ROM_LAT  = 1,
    parameter int          ANIM_DIV = 6,
    parameter logic [23:0] KEY_RGB  = 24'hFF00FF
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic              i_frame_start,
    input  logic [9:0]        i_DrawX,
    input  logic [9:0]        i_DrawY,
    input  logic [9:0]        i_pos_x,
    input  logic [9:0]        i_pos_y,
    input  logic              i_visible,
    input  logic              i_moving,
    input  logic              i_face_left,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [23:0]       i_rom_data,
    output logic              o_obj_on,
    output logic [23:0]       o_obj_pix
);

    localparam int XW       = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int YW       = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam int IW       = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;
    localparam int DW       = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam int FRAME_SZ = SPR_W * SPR_H;

    typedef enum logic {S_IDLE, S_WALK} state_t;

    // frame-latched object state
    logic [9:0]    r_px, r_py;
    logic          r_vis;
`ifdef SPRITE_MIRROR_EN
    logic          r_face;
`endif

    // animation
    state_t        r_state, w_state_nxt;
    logic [IW-1:0] r_anim_idx, w_idx_nxt;
    logic [DW-1:0] r_div_cnt, w_div_nxt;

    // stage 0
    logic [10:0]   w_dx, w_dy, w_px, w_py;
    logic [XW-1:0] w_rel_x, w_col;
    logic [YW-1:0] w_rel_y;
    logic          w_hit;
    logic [ADDR_W-1:0] w_addr;

    // hit alignment and output stage
    logic [ROM_LAT:1] r_hit_pipe;
    logic             w_on;

    // Shadow the game-logic position once per frame so a sprite never tears mid-frame.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_px  <= '0;
            r_py  <= '0;
            r_vis <= 1'b0;
        end else if (i_frame_start) begin
            r_px  <= i_pos_x;
            r_py  <= i_pos_y;
            r_vis <= i_visible;
        end
    end

`ifdef SPRITE_MIRROR_EN
    // The facing direction is latched alongside the position.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset)            r_face <= 1'b0;
        else if (i_frame_start) r_face <= i_face_left;
    end
`endif

    // Animation state register; it only moves on frame_start.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_state    <= S_IDLE;
            r_anim_idx <= '0;
            r_div_cnt  <= '0;
        end else if (i_frame_start) begin
            r_state    <= w_state_nxt;
            r_anim_idx <= w_idx_nxt;
            r_div_cnt  <= w_div_nxt;
        end
    end

    // Animation next state: walk while moving, otherwise idle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_moving)  w_state_nxt = S_WALK;
            S_WALK:  if (!i_moving) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Animation outputs. The IDLE->WALK frame already counts, so the first index step
    // lands on the ANIM_DIV-th frame_start seen with moving=1.
    always_comb begin
        w_idx_nxt = '0;
        w_div_nxt = '0;
        if (w_state_nxt == S_WALK) begin
            w_idx_nxt = r_anim_idx;
            if (r_div_cnt == DW'(ANIM_DIV - 1)) begin
                w_div_nxt = '0;
                w_idx_nxt = (r_anim_idx == IW'(N_FRAMES - 1)) ? '0 : r_anim_idx + 1'b1;
            end else begin
                w_div_nxt = r_div_cnt + 1'b1;
            end
        end
    end

    // Stage 0: 11-bit compare so a box hanging past the screen edge clips instead of wrapping.
    always_comb begin
        w_dx    = {1'b0, i_DrawX};
        w_dy    = {1'b0, i_DrawY};
        w_px    = {1'b0, r_px};
        w_py    = {1'b0, r_py};
        w_hit   = r_vis && (w_dx >= w_px) && (w_dx < w_px + 11'(SPR_W))
                        && (w_dy >= w_py) && (w_dy < w_py + 11'(SPR_H));
        w_rel_x = XW'(w_dx - w_px);
        w_rel_y = YW'(w_dy - w_py);
`ifdef SPRITE_MIRROR_EN
        w_col   = r_face ? (XW'(SPR_W - 1) - w_rel_x) : w_rel_x;
`else
        w_col   = w_rel_x;
`endif
        w_addr  = ADDR_W'(r_anim_idx) * ADDR_W'(FRAME_SZ)
                + ADDR_W'(w_rel_y) * ADDR_W'(SPR_W) + ADDR_W'(w_col);
    end

    // Stage 1: register the ROM address, which parks at 0 when there is no hit.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) o_rom_addr <= '0;
        else         o_rom_addr <= w_hit ? w_addr : '0;
    end

    // The hit flag rides a shift register so it meets the matching ROM word.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_hit_pipe <= '0;
        end else begin
            r_hit_pipe[1] <= w_hit;
            for (int k = 2; k <= ROM_LAT; k++) r_hit_pipe[k] <= r_hit_pipe[k-1];
        end
    end

    assign w_on = r_hit_pipe[ROM_LAT] && (i_rom_data != KEY_RGB);

    // Output stage: the key colour is transparent, and the pixel is zeroed when the object is off.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            o_obj_on  <= 1'b0;
            o_obj_pix <= '0;
        end else begin
            o_obj_on  <= w_on;
            o_obj_pix <= w_on ? i_rom_data : 24'h0;
        end
    end

endmodule

// File: tb/tb_sprite_fetch.sv
// Scoreboard bench for sprite_fetch (default parameters, ROM_LAT=1).
// The stimulus queues the expected address (+1 clk) and pixel (+2 clk); the monitor pops and compares them.
module tb_sprite_fetch;
    localparam logic [23:0] KEY = 24'hFF00FF;

    logic        clk = 1'b0, rst = 1'b1, fs = 1'b0;
    logic [9:0]  dx = '0, dy = '0, px = '0, py = '0;
    logic        vis = 1'b0, mov = 1'b0, face = 1'b0;
    logic [11:0] addr;
    logic [23:0] rdata, pix;
    logic        on;

    int checks = 0, failures = 0, cyc = 0;

    typedef struct { int due; logic [11:0] a; string nm; } exp_a_t;
    typedef struct { int due; logic on; logic [23:0] pix; string nm; } exp_o_t;
    exp_a_t qa[$];
    exp_o_t qo[$];

    always #5 clk = ~clk;

    // Sprite ROM model: address 5 holds the key colour, address 6 holds green, and every other word is {0A5, addr}.
    function automatic logic [23:0] rom_fn(input logic [11:0] a);
        if (a == 12'd5) return KEY;
        if (a == 12'd6) return 24'h00A000;
        return {12'h0A5, a};
    endfunction

    assign rdata = rom_fn(addr);

    sprite_fetch dut (
        .i_Clk(clk), .i_Reset(rst), .i_frame_start(fs),
        .i_DrawX(dx), .i_DrawY(dy), .i_pos_x(px), .i_pos_y(py),
        .i_visible(vis), .i_moving(mov), .i_face_left(face),
        .o_rom_addr(addr), .i_rom_data(rdata), .o_obj_on(on), .o_obj_pix(pix)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one pixel; hit/ea are the hand-computed hit flag and ROM address.
    task automatic drive(input logic [9:0] x, input logic [9:0] y, input logic f,
                         input logic hit, input logic [11:0] ea, input string nm);
        logic eon;
        @(negedge clk);
        dx = x; dy = y; fs = f;
        eon = hit && (rom_fn(ea) != KEY);
        qa.push_back('{cyc + 1, hit ? ea : 12'd0, nm});
        qo.push_back('{cyc + 2, eon, eon ? rom_fn(ea) : 24'h0, nm});
    endtask

    task automatic frame();
        drive(10'd0, 10'd0, 1'b1, 1'b0, 12'd0, "fs");
    endtask

    // Monitor: after each rising edge, compare every entry that has come due.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (qa.size() > 0 && qa[0].due <= cyc) begin
                chk({qa[0].nm, "_addr"}, 32'(addr), 32'(qa[0].a));
                void'(qa.pop_front());
            end
            while (qo.size() > 0 && qo[0].due <= cyc) begin
                chk({qo[0].nm, "_on"}, 32'(on), 32'(qo[0].on));
                chk({qo[0].nm, "_pix"}, 32'(pix), 32'(qo[0].pix));
                void'(qo.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        #2;
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_on", 32'(on), 32'd0);
        chk("rst_pix", 32'(pix), 32'd0);
        @(negedge clk); rst = 1'b0;

        // Before any frame_start the latched visibility is still 0.
        px = 10'd100; py = 10'd200; vis = 1'b1; face = 1'b1;
        drive(10'd100, 10'd200, 1'b0, 1'b0, 12'd0, "prelatch");
        frame();
`ifdef SPRITE_MIRROR_EN
        drive(10'd100, 10'd200, 1'b0, 1'b1, 12'd31, "mirror_tl");
        drive(10'd131, 10'd200, 1'b0, 1'b1, 12'd0, "mirror_tr");
`else
        drive(10'd100, 10'd200, 1'b0, 1'b1, 12'd0, "face_ignored");
`endif
        face = 1'b0;
        frame();
        drive(10'd100, 10'd200, 1'b0, 1'b1, 12'd0, "top_left");
        drive(10'd131, 10'd231, 1'b0, 1'b1, 12'd1023, "bot_right");
        drive(10'd132, 10'd231, 1'b0, 1'b0, 12'd0, "right_out");
        drive(10'd99, 10'd200, 1'b0, 1'b0, 12'd0, "left_out");
        drive(10'd100, 10'd232, 1'b0, 1'b0, 12'd0, "below_out");
        drive(10'd105, 10'd200, 1'b0, 1'b1, 12'd5, "key");
        drive(10'd106, 10'd200, 1'b0, 1'b1, 12'd6, "green");
        drive(10'd110, 10'd201, 1'b0, 1'b1, 12'd42, "inner");

        // Animation: the index steps on the 6th and 12th frame_start while moving.
        mov = 1'b1;
        repeat (5) frame();
        drive(10'd100, 10'd200, 1'b0, 1'b1, 12'd0, "anim5");
        frame();
        drive(10'd100, 10'd200, 1'b0, 1'b1, 12'd1024, "anim6");
        repeat (5) frame();
        drive(10'd100, 10'd200, 1'b0, 1'b1, 12'd1024, "anim11");
        frame();
        drive(10'd100, 10'd200, 1'b0, 1'b1, 12'd2048, "anim12");
        frame();
        drive(10'd101, 10'd200, 1'b0, 1'b1, 12'd2049, "anim13");
        mov = 1'b0;
        frame();
        drive(10'd100, 10'd200, 1'b0, 1'b1, 12'd0, "anim_stop");

        // A mid-frame position change waits for frame_start; a pixel on that same edge uses the old position.
        px = 10'd300;
        drive(10'd100, 10'd200, 1'b0, 1'b1, 12'd0, "old_pos");
        drive(10'd300, 10'd200, 1'b0, 1'b0, 12'd0, "new_pos_early");
        drive(10'd100, 10'd201, 1'b1, 1'b1, 12'd32, "fs_same_px");
        drive(10'd300, 10'd200, 1'b0, 1'b1, 12'd0, "new_pos");
        drive(10'd100, 10'd200, 1'b0, 1'b0, 12'd0, "old_pos_gone");
        drive(10'd331, 10'd231, 1'b0, 1'b1, 12'd1023, "new_pos_br");

        // Latched visible=0 keeps the object off and the address at 0.
        vis = 1'b0;
        frame();
        drive(10'd300, 10'd200, 1'b0, 1'b0, 12'd0, "invisible");

        // Clipping at the screen corner; column 0 must not alias a wrapped column.
        px = 10'd620; py = 10'd460; vis = 1'b1;
        frame();
        drive(10'd639, 10'd479, 1'b0, 1'b1, 12'd627, "clip_corner");
        drive(10'd0, 10'd460, 1'b0, 1'b0, 12'd0, "no_wrap");
        drive(10'd620, 10'd460, 1'b0, 1'b1, 12'd0, "clip_tl");

        // Reset in the middle of a sprite takes effect at once, with no clock edge.
        repeat (3) @(negedge clk);
        drive(10'd621, 10'd460, 1'b0, 1'b1, 12'd1, "pre_reset");
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("midrst_on", 32'(on), 32'd0);
        chk("midrst_pix", 32'(pix), 32'd0);
        chk("midrst_addr", 32'(addr), 32'd0);
        qa.delete(); qo.delete();
        @(negedge clk); rst = 1'b0;
        drive(10'd621, 10'd460, 1'b0, 1'b0, 12'd0, "post_reset");
        frame();
        drive(10'd621, 10'd460, 1'b0, 1'b1, 12'd1, "resumed");

        repeat (4) @(negedge clk);
        checks++;
        if (qa.size() != 0 || qo.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d addr / %0d pixel entries left, expected 0", qa.size(), qo.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
